// File: rtl/rgb_matrix_pkg.sv
// rgb_matrix_pkg: shared pattern modes, palette and intensity helpers
// for the RGB LED matrix pattern path.
package rgb_matrix_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_ROWBARS = 2'd1,
    MODE_COLBARS = 2'd2,
    MODE_GRAD    = 2'd3
  } pat_mode_e;

  localparam int MAX_BPC = 8;

  localparam logic [2:0] PALETTE [8] = '{
    3'b111, 3'b000, 3'b100, 3'b110,
    3'b010, 3'b011, 3'b001, 3'b101
  };

  // Sized for the widest channel; only the low BPC bits are ever nonzero.
  typedef struct packed {
    logic [MAX_BPC-1:0] r;
    logic [MAX_BPC-1:0] g;
    logic [MAX_BPC-1:0] b;
  } rgb_int_t;

  function automatic rgb_int_t pal_expand(
    input logic [2:0]         c,
    input logic [MAX_BPC-1:0] full
  );
    rgb_int_t v;
    v.r = c[2] ? full : '0;
    v.g = c[1] ? full : '0;
    v.b = c[0] ? full : '0;
    return v;
  endfunction

  function automatic logic [MAX_BPC-1:0] gamma(
    input logic [MAX_BPC-1:0] i,
    input int                 bpc
  );
    logic [2*MAX_BPC-1:0] w;
    w = (2*MAX_BPC)'(i) * (2*MAX_BPC)'(i)
      + (2*MAX_BPC)'((1 << bpc) - 1);
    return MAX_BPC'(w >> bpc);
  endfunction

endpackage

// File: rtl/rgb_pattern_scroll_ctrl.sv
// rgb_pattern_scroll_ctrl: per-frame mode latch, frame divider
// and horizontal scroll offset.
module rgb_pattern_scroll_ctrl
  import rgb_matrix_pkg::*;
#(
  parameter int COL_W      = 5,
  parameter int SCROLL_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [1:0]       mode_sel,
  input  logic             scroll_en,
  output logic [1:0]       mode_q,
  output logic [COL_W-1:0] scroll_ofs
);

  localparam int FC_W =
    (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [FC_W-1:0] FC_LAST =
    FC_W'(SCROLL_DIV - 1);

  pat_mode_e        r_mode;
  logic [FC_W-1:0]  r_frame_cnt;
  logic [COL_W-1:0] r_scroll_ofs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode       <= MODE_SOLID;
      r_frame_cnt  <= '0;
      r_scroll_ofs <= '0;
    end else if (frame_start) begin
      r_mode <= pat_mode_e'(mode_sel);
      if (r_frame_cnt == FC_LAST) begin
        r_frame_cnt <= '0;
        if (scroll_en)
          r_scroll_ofs <= r_scroll_ofs + COL_W'(1);
      end else begin
        r_frame_cnt <= r_frame_cnt + FC_W'(1);
      end
    end
  end

  assign mode_q     = r_mode;
  assign scroll_ofs = r_scroll_ofs;

endmodule

// File: rtl/rgb_pattern_gen.sv
// rgb_pattern_gen: 2-stage test-pattern pixel source for a HUB75 driver.
// Define RGB_PATGEN_GAMMA_EN to apply gamma to all channel intensities.
module rgb_pattern_gen
  import rgb_matrix_pkg::*;
#(
  parameter int COL_W      = 5,
  parameter int ROW_W      = 3,
  parameter int BPC        = 4,
  parameter int SCROLL_DIV = 4,
  parameter int PLANE_W    = (BPC > 1) ? $clog2(BPC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [1:0]         mode_sel,
  input  logic               scroll_en,
  input  logic [3*BPC-1:0]   solid_rgb,
  input  logic               pix_req,
  input  logic [COL_W-1:0]   col_count,
  input  logic [ROW_W-1:0]   row_count,
  input  logic [PLANE_W-1:0] plane,
  output logic               pix_valid,
  output logic [2:0]         LED_Top,
  output logic [2:0]         LED_Bottom,
  output logic [1:0]         mode_q
);

  localparam int HI_W = (BPC > 3) ? BPC : 3;
  localparam logic [MAX_BPC-1:0] FULL =
    MAX_BPC'((1 << BPC) - 1);

  logic [COL_W-1:0] w_scroll_ofs;
  logic [COL_W-1:0] w_sc;
  logic [HI_W-1:0]  w_sc_hi;
  logic [2:0]       w_idx;
  rgb_int_t         w_top;
  rgb_int_t         w_bot;
  rgb_int_t         w_top_g;
  rgb_int_t         w_bot_g;

  rgb_pattern_scroll_ctrl #(
    .COL_W      (COL_W),
    .SCROLL_DIV (SCROLL_DIV)
  ) u_scroll (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .mode_sel    (mode_sel),
    .scroll_en   (scroll_en),
    .mode_q      (mode_q),
    .scroll_ofs  (w_scroll_ofs)
  );

  assign w_sc    = col_count + w_scroll_ofs;
  assign w_sc_hi = HI_W'(w_sc >> (COL_W - HI_W));

  always_comb begin
    w_top = '0;
    w_bot = '0;
    w_idx = 3'd0;
    unique case (pat_mode_e'(mode_q))
      MODE_SOLID: begin
        w_top.r = MAX_BPC'(solid_rgb[3*BPC-1 -: BPC]);
        w_top.g = MAX_BPC'(solid_rgb[2*BPC-1 -: BPC]);
        w_top.b = MAX_BPC'(solid_rgb[BPC-1:0]);
        w_bot   = w_top;
      end
      MODE_ROWBARS: begin
        w_idx = row_count[2:0];
        w_top = pal_expand(PALETTE[w_idx], FULL);
        w_bot = w_top;
      end
      MODE_COLBARS: begin
        w_idx = w_sc_hi[HI_W-1 -: 3];
        w_top = pal_expand(PALETTE[w_idx], FULL);
        w_bot = pal_expand(PALETTE[w_idx + 3'd4], FULL);
      end
      MODE_GRAD: begin
        w_top.r = MAX_BPC'(w_sc_hi[HI_W-1 -: BPC]);
        w_bot.b = MAX_BPC'(w_sc_hi[HI_W-1 -: BPC]);
      end
    endcase
  end

`ifdef RGB_PATGEN_GAMMA_EN
  always_comb begin
    w_top_g.r = gamma(w_top.r, BPC);
    w_top_g.g = gamma(w_top.g, BPC);
    w_top_g.b = gamma(w_top.b, BPC);
    w_bot_g.r = gamma(w_bot.r, BPC);
    w_bot_g.g = gamma(w_bot.g, BPC);
    w_bot_g.b = gamma(w_bot.b, BPC);
  end
`else
  assign w_top_g = w_top;
  assign w_bot_g = w_bot;
`endif

  logic               r_s1_valid;
  logic [PLANE_W-1:0] r_s1_plane;
  rgb_int_t           r_s1_top;
  rgb_int_t           r_s1_bot;
  logic               r_pix_valid;
  logic [2:0]         r_led_top;
  logic [2:0]         r_led_bot;

  logic [2:0] w_pidx;
  logic       w_on;
  logic [2:0] w_top_bits;
  logic [2:0] w_bot_bits;

  // Planes beyond the channel depth read as off.
  assign w_pidx = 3'(r_s1_plane);
  assign w_on   = (32'(r_s1_plane) < BPC);

  assign w_top_bits = {r_s1_top.r[w_pidx],
                       r_s1_top.g[w_pidx],
                       r_s1_top.b[w_pidx]} & {3{w_on}};
  assign w_bot_bits = {r_s1_bot.r[w_pidx],
                       r_s1_bot.g[w_pidx],
                       r_s1_bot.b[w_pidx]} & {3{w_on}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_plane  <= '0;
      r_s1_top    <= '0;
      r_s1_bot    <= '0;
      r_pix_valid <= 1'b0;
      r_led_top   <= 3'b000;
      r_led_bot   <= 3'b000;
    end else begin
      r_s1_valid  <= pix_req;
      r_s1_plane  <= plane;
      r_s1_top    <= w_top_g;
      r_s1_bot    <= w_bot_g;
      r_pix_valid <= r_s1_valid;
      r_led_top   <= r_s1_valid ? w_top_bits : 3'b000;
      r_led_bot   <= r_s1_valid ? w_bot_bits : 3'b000;
    end
  end

  assign pix_valid  = r_pix_valid;
  assign LED_Top    = r_led_top;
  assign LED_Bottom = r_led_bot;

endmodule
